// File: rtl/lmsm_pkg.sv
// Shared types and default sizing for the LM/SM register-list sequencer.
package lmsm_pkg;

    localparam int LMSM_MASK_W = 8;
    localparam int LMSM_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lmsm_sequencer_lsb_find.sv
// Lowest-set-bit finder: index of the least significant 1 in vec, plus a found flag.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module lsb_find #(
    parameter int MASK_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic [MASK_W-1:0] vec,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks the register-list mask in ascending order, one transfer per handshake; LMSM_WRITEBACK_EN adds wb_addr.
// Latency: start to first xfer_valid 1 cycle; last handshake to done 1 cycle; empty mask gives done 1 cycle after start.
// Backpressure: a presented transfer holds until xfer_ready; one transfer per cycle with xfer_ready held high.
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int MASK_W = LMSM_MASK_W,
    parameter int ADDR_W = LMSM_ADDR_W,
    parameter int IDX_W  = $clog2(MASK_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [MASK_W-1:0] mask,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              xfer_ready,
    output logic              xfer_valid,
    output logic              xfer_store,
    output logic [IDX_W-1:0]  reg_idx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              done
`ifdef LMSM_WRITEBACK_EN
    ,
    output logic [ADDR_W-1:0] wb_addr
`endif
);

    state_t            state;
    logic [MASK_W-1:0] rem_mask;
    logic [MASK_W-1:0] nxt_mask;
    logic [IDX_W-1:0]  nxt_idx;
    logic              nxt_found;

    // Mask as it will stand after this edge; reg_idx is registered from it so
    // the next transfer is ready the cycle after a handshake.
    always_comb begin
        nxt_mask = rem_mask;
        if (state == IDLE && start) begin
            nxt_mask = mask;
        end else if (state == XFER && xfer_ready) begin
            nxt_mask = rem_mask & (rem_mask - MASK_W'(1));
        end
    end

    lsb_find #(
        .MASK_W (MASK_W),
        .IDX_W  (IDX_W)
    ) u_lsb_find (
        .vec   (nxt_mask),
        .idx   (nxt_idx),
        .found (nxt_found)
    );

`ifdef LMSM_WRITEBACK_EN
    logic [ADDR_W-1:0] pop_cnt;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < MASK_W; i++) begin
            pop_cnt = pop_cnt + ADDR_W'(mask[i]);
        end
    end

    // Captured at start; inputs may change freely afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_addr <= '0;
        end else if (state == IDLE && start) begin
            wb_addr <= base_addr + pop_cnt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem_mask   <= '0;
            xfer_valid <= 1'b0;
            xfer_store <= 1'b0;
            reg_idx    <= '0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem_mask   <= nxt_mask;
                        mem_addr   <= base_addr;
                        xfer_store <= is_store;
                        reg_idx    <= nxt_idx;
                        busy       <= 1'b1;
                        if (nxt_found) begin
                            state      <= XFER;
                            xfer_valid <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (xfer_ready) begin
                        rem_mask <= nxt_mask;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        reg_idx  <= nxt_idx;
                        if (!nxt_found) begin
                            state      <= DONE;
                            xfer_valid <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    xfer_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: per-cycle vector table plus hand-written reset sequences.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [7:0]  mask;
    logic [15:0] base_addr;
    logic        xfer_ready;
    logic        xfer_valid;
    logic        xfer_store;
    logic [2:0]  reg_idx;
    logic [15:0] mem_addr;
    logic        busy;
    logic        done;
`ifdef LMSM_WRITEBACK_EN
    logic [15:0] wb_addr;
`endif

    always #5 clk = ~clk;

    lmsm_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .mask       (mask),
        .base_addr  (base_addr),
        .xfer_ready (xfer_ready),
        .xfer_valid (xfer_valid),
        .xfer_store (xfer_store),
        .reg_idx    (reg_idx),
        .mem_addr   (mem_addr),
        .busy       (busy),
        .done       (done)
`ifdef LMSM_WRITEBACK_EN
        ,
        .wb_addr    (wb_addr)
`endif
    );

    // One row = inputs driven for this cycle + outputs expected during it.
    typedef struct {
        logic        start;
        logic [7:0]  mask;
        logic [15:0] base;
        logic        st;
        logic        rdy;
        logic        e_vld;
        logic        e_busy;
        logic        e_done;
        logic        e_st;
        logic [2:0]  e_idx;
        logic [15:0] e_addr;
        logic [15:0] e_wb;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   row_no = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [7:0] m, input logic [15:0] b, input logic st,
                       input logic rdy, input logic ev, input logic eb, input logic ed,
                       input logic est, input logic [2:0] ei, input logic [15:0] ea,
                       input logic [15:0] ew);
        vec_t v;
        v.start = s;  v.mask = m;    v.base = b;    v.st = st;  v.rdy = rdy;
        v.e_vld = ev; v.e_busy = eb; v.e_done = ed; v.e_st = est;
        v.e_idx = ei; v.e_addr = ea; v.e_wb = ew;
        tbl.push_back(v);
    endtask

    task automatic idle_row();
        add(0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) begin
            @(negedge clk);
            start      = tbl[i].start;
            mask       = tbl[i].mask;
            base_addr  = tbl[i].base;
            is_store   = tbl[i].st;
            xfer_ready = tbl[i].rdy;
            chk($sformatf("row%0d xfer_valid", row_no), 32'(xfer_valid), 32'(tbl[i].e_vld));
            chk($sformatf("row%0d busy", row_no), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d done", row_no), 32'(done), 32'(tbl[i].e_done));
            if (tbl[i].e_vld) begin
                chk($sformatf("row%0d reg_idx", row_no), 32'(reg_idx), 32'(tbl[i].e_idx));
                chk($sformatf("row%0d mem_addr", row_no), 32'(mem_addr), 32'(tbl[i].e_addr));
                chk($sformatf("row%0d xfer_store", row_no), 32'(xfer_store), 32'(tbl[i].e_st));
            end
`ifdef LMSM_WRITEBACK_EN
            if (tbl[i].e_done)
                chk($sformatf("row%0d wb_addr", row_no), 32'(wb_addr), 32'(tbl[i].e_wb));
`endif
            row_no++;
        end
        tbl.delete();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " xfer_valid"}, 32'(xfer_valid), 32'd0);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " done"}, 32'(done), 32'd0);
        chk({nm, " reg_idx"}, 32'(reg_idx), 32'd0);
        chk({nm, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, " xfer_store"}, 32'(xfer_store), 32'd0);
`ifdef LMSM_WRITEBACK_EN
        chk({nm, " wb_addr"}, 32'(wb_addr), 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; mask = '0;
        base_addr = '0; xfer_ready = 1'b0;
        #1;
        chk_all_zero("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // mask A5 from 0100 at full throughput
        add(1, 8'hA5, 16'h0100, 0, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 0, 3'd0, 16'h0100, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 0, 3'd2, 16'h0101, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 0, 3'd5, 16'h0102, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 0, 3'd7, 16'h0103, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 0, 1, 1, 0, 3'd0, 16'h0000, 16'h0104);
        idle_row();
        // backpressure: three stalled cycles on the first transfer
        add(1, 8'h03, 16'h0200, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 0, 1, 1, 0, 1, 3'd0, 16'h0200, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 0, 1, 1, 0, 1, 3'd0, 16'h0200, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 0, 1, 1, 0, 1, 3'd0, 16'h0200, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 1, 3'd0, 16'h0200, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 1, 3'd1, 16'h0201, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 0, 1, 1, 0, 3'd0, 16'h0000, 16'h0202);
        idle_row();
        // empty mask
        add(1, 8'h00, 16'h0400, 0, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 0, 1, 1, 0, 3'd0, 16'h0000, 16'h0400);
        idle_row();
        // address wrap
        add(1, 8'hC0, 16'hFFFF, 1, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 1, 3'd6, 16'hFFFF, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 1, 3'd7, 16'h0000, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 0, 1, 1, 0, 3'd0, 16'h0000, 16'h0001);
        idle_row();
        // start/mask/base/is_store changes mid-sequence and in DONE are ignored
        add(1, 8'h81, 16'h0300, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        add(1, 8'h02, 16'h9999, 0, 0, 1, 1, 0, 1, 3'd0, 16'h0300, 16'h0000);
        add(1, 8'h02, 16'h9999, 0, 1, 1, 1, 0, 1, 3'd0, 16'h0300, 16'h0000);
        add(1, 8'h02, 16'h9999, 0, 1, 1, 1, 0, 1, 3'd7, 16'h0301, 16'h0000);
        add(1, 8'h02, 16'h9999, 0, 1, 0, 1, 1, 0, 3'd0, 16'h0000, 16'h0302);
        idle_row();
        // reset lands on the second transfer
        add(1, 8'h0F, 16'h0500, 0, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 0, 3'd0, 16'h0500, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 0, 3'd1, 16'h0501, 16'h0000);
        run_tbl();

        #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("inrst%0d done", i), 32'(done), 32'd0);
            chk($sformatf("inrst%0d xfer_valid", i), 32'(xfer_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d done", i), 32'(done), 32'd0);
            chk($sformatf("postrst%0d xfer_valid", i), 32'(xfer_valid), 32'd0);
            chk($sformatf("postrst%0d busy", i), 32'(busy), 32'd0);
        end

        // fresh sequence from a new base after the abort
        add(1, 8'h11, 16'h0600, 1, 1, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 1, 3'd0, 16'h0600, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 1, 1, 0, 1, 3'd4, 16'h0601, 16'h0000);
        add(0, 8'h00, 16'h0000, 0, 1, 0, 1, 1, 0, 3'd0, 16'h0000, 16'h0602);
        idle_row();
        idle_row();
        run_tbl();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
